// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: memory-stage controller between the MEM stage and an external
// single-port SRAM. One MEM-stage read or write becomes BEATS narrow SRAM beats,
// each lasting WAIT_STATES cycles. `ready` is the pipeline's global freeze
// (freeze = ~ready).
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   mem_r_en     read request from MEM stage
//   mem_w_en     write request from MEM stage (wins over mem_r_en)
//   addr         byte address, word aligned
//   wdata        write data
//   rdata        read data, valid while ready=1 in DONE; held until next read
//   ready        1 = pipeline may advance
//   sram_addr    SRAM beat address
//   sram_dq_out  SRAM write data
//   sram_dq_oe   1 = drive sram_dq_out onto the bus
//   sram_dq_in   SRAM read data
//   sram_we_n    SRAM write strobe, active-low
module sram_mem_ctrl #(
  parameter int ADDR_LEN      = 32,
  parameter int DATA_LEN      = 32,
  parameter int SRAM_DATA_LEN = 16,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int BASE_ADDR     = 1024,
  parameter int WAIT_STATES   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_r_en,
  input  logic                     mem_w_en,
  input  logic [ADDR_LEN-1:0]      addr,
  input  logic [DATA_LEN-1:0]      wdata,
  output logic [DATA_LEN-1:0]      rdata,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  output logic                     sram_dq_oe,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_we_n
);

  localparam int BEATS      = DATA_LEN / SRAM_DATA_LEN;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W      = $clog2(WAIT_STATES);
  localparam int WORD_SHIFT = $clog2(DATA_LEN / 8);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(WAIT_STATES - 1);
  localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_LEN-1:0] BASE      = ADDR_LEN'(BASE_ADDR);
  localparam logic [ADDR_LEN-1:0] BEATS_A   = ADDR_LEN'(BEATS);

  logic [1:0]                              state;
  logic [BEAT_W-1:0]                       beat;
  logic [CNT_W-1:0]                        cnt;
  logic                                    op_write;
  logic [ADDR_LEN-1:0]                     addr_q;
  logic [BEATS-1:0][SRAM_DATA_LEN-1:0]     wdata_q;
  logic [BEATS-1:0][SRAM_DATA_LEN-1:0]     rdata_q;
  logic [ADDR_LEN-1:0]                     word;
  logic [ADDR_LEN-1:0]                     beat_addr;
  logic                                    request;

  assign request = mem_r_en | mem_w_en;
  assign rdata   = rdata_q;

  // Addresses below BASE wrap through the subtraction; the final truncation
  // to SRAM_ADDR_LEN makes the wrap modulo the SRAM size.
  assign word      = (addr_q - BASE) >> WORD_SHIFT;
  assign beat_addr = word * BEATS_A + ADDR_LEN'(beat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat     <= '0;
      cnt      <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            op_write <= mem_w_en;
            beat     <= '0;
            cnt      <= '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            // Read data is captured at the last cycle of the beat, after the
            // SRAM has had the full wait-state window to settle.
            if (!op_write) rdata_q[beat] <= sram_dq_in;
            if (beat == BEAT_LAST) begin
              beat  <= '0;
              state <= DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decode from registered state only, so an asserted reset
  // returns them to idle values immediately.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: ready = ~request;
      ACCESS: begin
        sram_addr = SRAM_ADDR_LEN'(beat_addr);
        if (op_write) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[beat];
          // Strobe released on the last cycle for address/data hold.
          sram_we_n   = (cnt == CNT_LAST);
        end
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: randomized self-checking bench for sram_mem_ctrl.
// Instance a uses default parameters; instance b uses SRAM_DATA_LEN=32,
// WAIT_STATES=2. Each has a behavioural SRAM; expectations come from an
// address/data reference map computed from the mapping rules.
module tb_sram_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a (defaults)
  logic        a_r, a_w, a_ready, a_oe, a_we_n;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [17:0] a_sram_addr;
  logic [15:0] a_dq_out, a_dq_in;

  // instance b (32-bit SRAM, 2 wait states)
  logic        b_r, b_w, b_ready, b_oe, b_we_n;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [17:0] b_sram_addr;
  logic [31:0] b_dq_out, b_dq_in;

  sram_mem_ctrl dut_a (
    .clk(clk), .rst(rst), .mem_r_en(a_r), .mem_w_en(a_w), .addr(a_addr),
    .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready), .sram_addr(a_sram_addr),
    .sram_dq_out(a_dq_out), .sram_dq_oe(a_oe), .sram_dq_in(a_dq_in),
    .sram_we_n(a_we_n)
  );

  sram_mem_ctrl #(.SRAM_DATA_LEN(32), .WAIT_STATES(2)) dut_b (
    .clk(clk), .rst(rst), .mem_r_en(b_r), .mem_w_en(b_w), .addr(b_addr),
    .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready), .sram_addr(b_sram_addr),
    .sram_dq_out(b_dq_out), .sram_dq_oe(b_oe), .sram_dq_in(b_dq_in),
    .sram_we_n(b_we_n)
  );

  // behavioural SRAMs
  logic [15:0] sram_a [0:262143];
  logic [31:0] sram_b [0:262143];
  assign a_dq_in = sram_a[a_sram_addr];
  assign b_dq_in = sram_b[b_sram_addr];
  always @(negedge clk) begin
    if (!a_we_n) sram_a[a_sram_addr] <= a_dq_out;
    if (!b_we_n) sram_b[b_sram_addr] <= b_dq_out;
  end

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model for instance a
  logic [15:0] ref_mem [int unsigned];
  logic [31:0] last_rd;

  function automatic logic [15:0] init_val(input int unsigned loc);
    return 16'(loc * 32'd40503 ^ 32'h5A5A);
  endfunction

  function automatic int unsigned loc_of(input logic [31:0] ad, input int unsigned b);
    int unsigned off;
    off = ad - 32'd1024;
    return ((off / 4) * 2 + b) % 262144;
  endfunction

  function automatic logic [15:0] ref_get(input int unsigned loc);
    return ref_mem.exists(loc) ? ref_mem[loc] : init_val(loc);
  endfunction

  // One MEM-stage access on instance a. Request drives mid-cycle 0; each
  // following cycle is sampled at its falling edge.
  task automatic access_a(input logic rd, input logic wr, input logic [31:0] ad,
                          input logic [31:0] wd, input logic scramble);
    int unsigned n, we_cnt, oe_cnt, b;
    logic done;
    logic [15:0] exp_dq;
    @(negedge clk);
    a_r = rd; a_w = wr; a_addr = ad; a_wdata = wd;
    #1;
    check("freeze_cycle0", a_ready, 1'b0);
    n = 0; we_cnt = 0; oe_cnt = 0; done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (!a_we_n) we_cnt++;
      if (a_oe) oe_cnt++;
      if (a_ready) begin
        done = 1'b1;
        n = k;
      end else if (k <= 6) begin
        b = (k - 1) / 3;
        check("sram_addr", a_sram_addr, 64'(loc_of(ad, b)));
        if (wr) begin
          exp_dq = (b == 0) ? wd[15:0] : wd[31:16];
          check("dq_out", a_dq_out, exp_dq);
        end
      end
      // inputs outside IDLE must be ignored
      if (scramble && !done) begin
        a_r = 1'($urandom); a_w = 1'($urandom); a_addr = $urandom; a_wdata = $urandom;
      end
    end
    check("latency", n, 7);
    if (rd && !wr) last_rd = {ref_get(loc_of(ad, 1)), ref_get(loc_of(ad, 0))};
    check("rdata", a_rdata, last_rd);
    check("we_cycles", we_cnt, wr ? 4 : 0);
    check("oe_cycles", oe_cnt, wr ? 6 : 0);
    if (wr) begin
      ref_mem[loc_of(ad, 0)] = wd[15:0];
      ref_mem[loc_of(ad, 1)] = wd[31:16];
      check("sram_lo", sram_a[loc_of(ad, 0)], wd[15:0]);
      check("sram_hi", sram_a[loc_of(ad, 1)], wd[31:16]);
    end
    a_r = 1'b0; a_w = 1'b0;
  endtask

  initial begin
    int unsigned op, we_cnt;
    logic [31:0] ad;
    rst = 1'b0;
    a_r = 0; a_w = 0; a_addr = '0; a_wdata = '0;
    b_r = 0; b_w = 0; b_addr = '0; b_wdata = '0;
    last_rd = '0;
    for (int unsigned i = 0; i < 262144; i++) begin
      sram_a[i] = init_val(i);
      sram_b[i] = '0;
    end
    sram_a[2] = 16'h1234; ref_mem[2] = 16'h1234;
    sram_a[3] = 16'hABCD; ref_mem[3] = 16'hABCD;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", a_ready, 1'b1);
    check("rst_we_n", a_we_n, 1'b1);
    check("rst_oe", a_oe, 1'b0);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_b_ready", b_ready, 1'b1);

    // directed cases on the default instance
    access_a(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
    access_a(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
    check("read_1028", a_rdata, 32'hABCD1234);
    access_a(1'b1, 1'b1, 32'd1032, 32'h55AA00FF, 1'b0);
    check("rw_keeps_rdata", a_rdata, 32'hABCD1234);
    access_a(1'b1, 1'b0, 32'd1000, 32'h0, 1'b0);  // below base: wraps

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) ad = 32'd1024 + 4 * $urandom_range(0, 15);
      else ad = $urandom & 32'hFFFF_FFFC;
      access_a(op != 1, op != 0, ad, $urandom, 1'($urandom));
    end

    // async reset in cycle 3 of a write
    @(negedge clk);
    a_w = 1'b1; a_addr = 32'd1100; a_wdata = 32'h1357_2468;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_we_n", a_we_n, 1'b1);
    check("arst_oe", a_oe, 1'b0);
    check("arst_addr", a_sram_addr, 18'h0);
    check("arst_dq", a_dq_out, 16'h0);
    check("arst_rdata", a_rdata, 32'h0);
    ref_mem[loc_of(32'd1100, 0)] = 16'h2468;  // beat 0 completed before reset
    last_rd = '0;
    a_w = 1'b0;
    we_cnt = 0;
    repeat (2) @(negedge clk) if (!a_we_n) we_cnt++;
    rst = 1'b1;
    repeat (8) @(negedge clk) if (!a_we_n) we_cnt++;
    check("arst_no_strobe", we_cnt, 0);
    check("arst_ready", a_ready, 1'b1);
    access_a(1'b1, 1'b0, 32'd1100, 32'h0, 1'b0);

    // instance b: write then read 0xCAFEF00D at 1024+4*10
    @(negedge clk);
    b_w = 1'b1; b_addr = 32'd1064; b_wdata = 32'hCAFEF00D;
    #1 check("b_w_c0_ready", b_ready, 1'b0);
    @(negedge clk);
    check("b_w_c1_ready", b_ready, 1'b0);
    check("b_w_addr", b_sram_addr, 18'd10);
    check("b_w_we", b_we_n, 1'b0);
    check("b_w_oe", b_oe, 1'b1);
    @(negedge clk);
    check("b_w_c2_ready", b_ready, 1'b0);
    check("b_w_hold", b_we_n, 1'b1);
    @(negedge clk);
    check("b_w_c3_ready", b_ready, 1'b1);
    check("b_sram", sram_b[10], 32'hCAFEF00D);
    b_w = 1'b0;
    @(negedge clk);
    b_r = 1'b1;
    #1 check("b_r_c0_ready", b_ready, 1'b0);
    @(negedge clk);
    check("b_r_addr", b_sram_addr, 18'd10);
    check("b_r_oe", b_oe, 1'b0);
    @(negedge clk);
    check("b_r_c2_ready", b_ready, 1'b0);
    @(negedge clk);
    check("b_r_c3_ready", b_ready, 1'b1);
    check("b_rdata", b_rdata, 32'hCAFEF00D);
    b_r = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Parametrised memory-stage controller between the MEM stage and an external single-port SRAM.
- Replaces the fixed-latency memory path. Turns one MEM-stage read or write into a sequence of narrow SRAM beats with configurable wait states.
- Drives `ready`, which the pipeline uses as its global freeze (freeze = ~ready).
- Generalises the current fixed path with configurable data width, SRAM width, base address and wait states.

Parameters:
- ADDR_LEN, 32, MEM-stage byte-address width.
- DATA_LEN, 32, MEM-stage data word width.
- SRAM_DATA_LEN, 16, SRAM data bus width; DATA_LEN must be an integer multiple; BEATS = DATA_LEN/SRAM_DATA_LEN.
- SRAM_ADDR_LEN, 18, SRAM address width.
- BASE_ADDR, 1024, byte address mapped to SRAM location 0.
- WAIT_STATES, 3, cycles per SRAM beat; must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- mem_r_en  in  1  read request from MEM stage
- mem_w_en  in  1  write request from MEM stage
- addr  in  ADDR_LEN  byte address, word aligned
- wdata  in  DATA_LEN  write data
- rdata  out  DATA_LEN  read data, valid while ready=1 in DONE
- ready  out  1  1 = pipeline may advance
- sram_addr  out  SRAM_ADDR_LEN  SRAM beat address
- sram_dq_out  out  SRAM_DATA_LEN  SRAM write data
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus
- sram_dq_in  in  SRAM_DATA_LEN  SRAM read data
- sram_we_n  out  1  SRAM write strobe, active-low

Behaviour:
- Reset (rst=0, async) forces: state=IDLE, beat=0, wait counter=0, rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1. Reset mid-access aborts immediately with no further SRAM strobes.
- State machine has three states: IDLE, ACCESS, DONE.
- IDLE:
  - ready = ~(mem_r_en | mem_w_en), combinational, so the pipeline freezes in the same cycle the request appears.
  - On a request: latch addr, wdata and op; go to ACCESS with beat=0 and cnt=0.
  - If mem_r_en and mem_w_en are both 1, the request is treated as a write.
- ACCESS:
  - ready=0.
  - cnt counts 0..WAIT_STATES-1; at WAIT_STATES-1, cnt resets and beat increments.
  - After beat BEATS-1 completes, go to DONE.
  - Duration is exactly BEATS*WAIT_STATES cycles.
- DONE:
  - ready=1 for exactly one cycle, then go to IDLE.
  - The pipeline advances on this edge. A new request visible in the following IDLE cycle starts a new access; back-to-back accesses cost no extra idle cycle beyond DONE.
- Latency: request in cycle 0 gives ready=1 in cycle BEATS*WAIT_STATES+1. Defaults: BEATS=2, W=3, ready in cycle 7.
- Address mapping:
  - word = (addr - BASE_ADDR) >> log2(DATA_LEN/8).
  - sram_addr = word*BEATS + beat, truncated to SRAM_ADDR_LEN.
  - addr below BASE_ADDR wraps modulo 2^SRAM_ADDR_LEN; no fault is raised.
- Write beat:
  - sram_dq_oe=1 for all cycles of the beat.
  - sram_dq_out = wdata slice [beat*SRAM_DATA_LEN +: SRAM_DATA_LEN], low slice first.
  - sram_we_n=0 for cnt 0..WAIT_STATES-2 and 1 at cnt=WAIT_STATES-1, giving address/data hold.
- Read beat:
  - sram_dq_oe=0, sram_we_n=1.
  - sram_dq_in is sampled at cnt=WAIT_STATES-1 into rdata slice [beat*SRAM_DATA_LEN +: SRAM_DATA_LEN].
- rdata holds its value until the next read completes; writes leave rdata unchanged.
- Request inputs are ignored outside IDLE; the latched copies are used. Request deassertion mid-access does not abort.
- In IDLE and DONE: sram_we_n=1 and sram_dq_oe=0.

Test Plan:
- Reset then idle, no request: ready=1, sram_we_n=1, sram_dq_oe=0, rdata=0.
- Write addr=1024, wdata=0xDEADBEEF (defaults):
  - ready=0 from cycle 0 to cycle 6, ready=1 in cycle 7.
  - sram_addr=0 carries 0xBEEF and sram_addr=1 carries 0xDEAD.
  - we_n is low for 2 cycles per beat.
- Read addr=1028 with SRAM model holding 0x1234 at location 2 and 0xABCD at location 3: rdata=0xABCD1234 while ready=1 in cycle 7.
- Simultaneous r/w at addr=1032, wdata=0x55AA00FF: performs a write to locations 4 and 5; rdata is unchanged.
- rst pulsed low in cycle 3 of a write: outputs return to reset values asynchronously and no we_n pulse occurs afterwards. After release with no request, ready=1.
- Parameter sweep SRAM_DATA_LEN=32, WAIT_STATES=2, write then read of 0xCAFEF00D at addr 1024+4*10: ready in cycle 3 for each access, sram_addr=10, and the read returns 0xCAFEF00D.
